// File: rtl/dm_seq.sv
// Single-port data memory with a valid/ready request port, byte strobes and 1- or 2-cycle read latency.
// After reset a sequential engine fills one word per cycle; no request is accepted until the fill completes.
module dm_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int READ_LAT   = 1,
  parameter int INIT_MODE  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    init_done,
  output logic                    addr_err
);

  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       cnt_q, cnt_d;
  logic                    init_done_q, init_done_d;
  logic                    addr_err_q, addr_err_d;
  logic                    p0_vld_q, p0_vld_d;
  logic [DATA_WIDTH-1:0]   p0_dat_q, p0_dat_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdat;
  logic [NB-1:0]           mem_be;

  logic                    accept;
  logic                    in_range;

  assign accept   = req_valid && init_done_q;
  assign in_range = ({1'b0, req_addr} < (ADDR_W+1)'(DEPTH));

  // The init engine and the request port share the single write port; they never overlap in time.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    addr_err_d  = addr_err_q;
    p0_vld_d    = 1'b0;
    p0_dat_d    = p0_dat_q;
    mem_we      = 1'b0;
    mem_addr    = cnt_q;
    mem_wdat    = '0;
    mem_be      = '0;
    case (state_q)
      ST_INIT: begin
        mem_we   = 1'b1;
        mem_be   = '1;
        mem_addr = cnt_q;
        mem_wdat = (INIT_MODE == 1) ? DATA_WIDTH'(cnt_q) : '0;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (!in_range) addr_err_d = 1'b1;
          if (req_we) begin
            mem_we   = in_range;
            mem_addr = req_addr;
            mem_wdat = req_wdata;
            mem_be   = req_be;
          end else begin
            p0_vld_d = 1'b1;
            p0_dat_d = in_range ? mem_q[req_addr] : '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      addr_err_q  <= 1'b0;
      p0_vld_q    <= 1'b0;
      p0_dat_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      addr_err_q  <= addr_err_d;
      p0_vld_q    <= p0_vld_d;
      p0_dat_q    <= p0_dat_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (mem_we && mem_be[k]) mem_q[mem_addr][8*k +: 8] <= mem_wdat[8*k +: 8];
    end
  end

  // Second stage only exists for the two-cycle configuration; it holds its data between responses.
  if (READ_LAT == 2) begin : g_lat2
    logic                  p1_vld_q, p1_vld_d;
    logic [DATA_WIDTH-1:0] p1_dat_q, p1_dat_d;

    always_comb begin
      p1_vld_d = p0_vld_q;
      p1_dat_d = p0_vld_q ? p0_dat_q : p1_dat_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p1_vld_q <= 1'b0;
        p1_dat_q <= '0;
      end else begin
        p1_vld_q <= p1_vld_d;
        p1_dat_q <= p1_dat_d;
      end
    end

    assign rsp_valid = p1_vld_q;
    assign rsp_rdata = p1_dat_q;
  end else begin : g_lat1
    assign rsp_valid = p0_vld_q;
    assign rsp_rdata = p0_dat_q;
  end

  assign req_ready = init_done_q;
  assign init_done = init_done_q;
  assign addr_err  = addr_err_q;

endmodule
